regfile_alu_unit: RTL and testbench
===================================

Name: regfile_alu_unit

Overview:
Combined execute-stage datapath slice for the single-cycle RV32 core.
- Integer register file: 32 x 32-bit, two combinational read ports, one synchronous write port.
- 32-bit combinational ALU driven by a 4-bit opcode.
- 3-to-8 one-hot decoder for the instruction funct3 field.
The instruction decoder and PC logic sit outside this block and drive its operands, write-back data and control.

Parameters:
XLEN, 32, datapath width of registers, ALU operands and result.
NREG, 32, number of architectural registers; address width is log2(NREG)=5.

Ports:
clk  input  1  rising-edge clock for register writes.
reset  input  1  asynchronous reset, active-low (0 = reset asserted).
wen  input  1  register write enable.
waddr  input  5  write register index.
wdata  input  XLEN  write-back data.
raddr1  input  5  read port 1 index (rs1).
rdata1  output  XLEN  read port 1 data.
raddr2  input  5  read port 2 index (rs2).
rdata2  output  XLEN  read port 2 data.
alu_src1  input  XLEN  ALU operand A.
alu_src2  input  XLEN  ALU operand B.
alu_op  input  4  ALU operation select.
alu_result  output  XLEN  ALU result.
funct3  input  3  funct3 field.
funct3_d  output  8  one-hot decode of funct3.

Behaviour:
Register file:
- Reset low clears all 32 registers to 0 immediately, without waiting for a clock edge.
- Registers hold 0 for as long as reset stays low; writes are ignored while reset is low.
- Write: on the rising clk edge with reset high and wen=1 and waddr!=0, regs[waddr] <= wdata.
- Index 0 is hardwired zero: writes to x0 are discarded, and reads of x0 always return 0.
- Reads are combinational: rdata1=regs[raddr1], rdata2=regs[raddr2].
- No write-to-read bypass: in the cycle a write is issued, a read of the same index returns the old value; the new value is visible after the edge.
- Both ports may read the same index simultaneously.

ALU:
- Purely combinational, zero latency, no reset dependence.
- All arithmetic is modulo 2^32; overflow and carry are ignored.
- Shift amount is alu_src2[4:0].
- alu_op encoding:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 SLL: A << shamt
  - 3 SLT: signed A<B, result 1 else 0
  - 4 SLTU: unsigned A<B, result 1 else 0
  - 5 XOR: A^B
  - 6 SRL: logical right shift of A by shamt
  - 7 SRA: arithmetic right shift of A by shamt
  - 8 OR: A|B
  - 9 AND: A&B
  - 10 PASSB: B (used for LUI)
  - 11–15: result 0.

Decoder:
- Combinational: funct3_d[i]=1 exactly when funct3==i; all other bits are 0.
- Exactly one bit is set for every input value.

General:
- The block has no other state and no handshakes.
- Outputs after reset: rdata1 and rdata2 read 0 for every index; alu_result and funct3_d follow their inputs.

Test Plan:
- Reset: preload x5=0x1234, then drive reset=0 mid-cycle with no clk edge -> rdata1 for raddr1=5 reads 0 immediately; a write with wen=1 issued while reset is low has no effect.
- Write/read: wen=1, waddr=3, wdata=0xDEADBEEF, then one edge -> raddr1=3 and raddr2=3 both read 0xDEADBEEF; in the same cycle before the edge they read the old value 0.
- x0: wen=1, waddr=0, wdata=0xFFFFFFFF, then an edge -> rdata1 for raddr1=0 reads 0.
- ALU arithmetic:
  - ADD 0xFFFFFFFF+1 -> 0.
  - SUB 0-1 -> 0xFFFFFFFF.
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - SLTU 0xFFFFFFFF vs 1 -> 0.
- ALU shifts and logic:
  - SRA 0x80000000 by B=0x21 -> 0xC0000000 (shamt=1).
  - SRL same operands -> 0x40000000.
  - SLL 1 by 31 -> 0x80000000.
  - PASSB B=0x12345000 -> 0x12345000.
  - op=12 -> 0.
- Decoder: sweep funct3 0..7 -> funct3_d = 0x01,0x02,0x04,...,0x80, with exactly one bit set each time.

Source files
------------

// File: rtl/regfile_alu_unit.sv
// Execute-stage datapath slice: 32x32 integer register file (2R/1W, x0 hardwired
// to zero, no write-to-read bypass), combinational ALU and funct3 one-hot decoder.
module regfile_alu_unit #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic [XLEN-1:0] alu_src1,
  input  logic [XLEN-1:0] alu_src2,
  input  logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_result,
  input  logic [2:0]      funct3,
  output logic [7:0]      funct3_d
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_PASSB = 4'd10
  } alu_op_e;

  logic [XLEN-1:0] regs [NREG];

  // reset is active-low and clears the whole array without a clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wen && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // x0 forced to zero on the read side as well, so it never depends on storage
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

  logic [4:0] shamt;
  assign shamt = alu_src2[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:   alu_result = alu_src1 + alu_src2;
      OP_SUB:   alu_result = alu_src1 - alu_src2;
      OP_SLL:   alu_result = alu_src1 << shamt;
      OP_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
      OP_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (alu_src1 < alu_src2)};
      OP_XOR:   alu_result = alu_src1 ^ alu_src2;
      OP_SRL:   alu_result = alu_src1 >> shamt;
      OP_SRA:   alu_result = XLEN'($signed(alu_src1) >>> shamt);
      OP_OR:    alu_result = alu_src1 | alu_src2;
      OP_AND:   alu_result = alu_src1 & alu_src2;
      OP_PASSB: alu_result = alu_src2;
      default:  alu_result = '0;
    endcase
  end

  assign funct3_d = 8'b0000_0001 << funct3;

endmodule

// File: tb/tb_regfile_alu_unit.sv
// Self-checking bench for regfile_alu_unit: directed cases plus randomized
// traffic compared against an array-based register model and arithmetic ALU model.
module tb_regfile_alu_unit;

  logic        clk;
  logic        reset;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic [2:0]  funct3;
  logic [7:0]  funct3_d;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_regs [32];
  logic [31:0] exp_q [$];

  regfile_alu_unit dut (
    .clk        (clk),
    .reset      (reset),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .funct3     (funct3),
    .funct3_d   (funct3_d)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
  endtask

  // ALU reference from the operation definitions, using wide signed arithmetic
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    int s;
    logic [31:0] fill;
    s  = int'(b % 32);
    sa = a[31] ? longint'(a) - 64'sd4294967296 : longint'(a);
    sb = b[31] ? longint'(b) - 64'sd4294967296 : longint'(b);
    fill = (s == 0) ? 32'h0 : ~(32'hFFFF_FFFF >> s);
    case (op)
      4'd0:    return 32'(longint'(a) + longint'(b));
      4'd1:    return 32'(longint'(a) - longint'(b));
      4'd2:    return 32'(longint'(a) * (64'sd1 << s));
      4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:    return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return 32'(longint'(a) / (64'sd1 << s));
      4'd7:    return (a >> s) | (a[31] ? fill : 32'h0);
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return 32'h0;
    endcase
  endfunction

  // driver: one write, applied on the next rising edge
  task automatic do_write(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    wen = 1'b1; waddr = idx; wdata = val;
    @(posedge clk);
    if (reset && idx != 5'd0) model_regs[idx] = val;
    #1 wen = 1'b0;
  endtask

  task automatic alu_case(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    alu_op = op; alu_src1 = a; alu_src2 = b;
    #1 check_eq(tag, alu_result, exp);
  endtask

  initial begin
    logic [7:0] exp_d;
    reset = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; alu_src1 = '0; alu_src2 = '0; alu_op = '0; funct3 = '0;
    model_clear();

    // reset state
    repeat (2) @(negedge clk);
    raddr1 = 5'd5; raddr2 = 5'd31;
    #1 check_eq("rst_rd1", rdata1, 32'h0);
    check_eq("rst_rd2", rdata2, 32'h0);
    reset = 1'b1;

    // async reset clears preloaded register with no clock edge
    do_write(5'd5, 32'h0000_1234);
    @(negedge clk);
    raddr1 = 5'd5;
    #1 check_eq("preload_x5", rdata1, 32'h0000_1234);
    #1 reset = 1'b0;
    model_clear();
    #1 check_eq("async_clr_x5", rdata1, 32'h0);
    wen = 1'b1; waddr = 5'd5; wdata = 32'hAAAA_5555;
    @(posedge clk);
    @(negedge clk);
    #1 check_eq("wr_in_reset_ignored", rdata1, 32'h0);
    wen = 1'b0;
    #1 reset = 1'b1;
    #1 check_eq("after_release_x5", rdata1, 32'h0);

    // write/read with no bypass
    @(negedge clk);
    wen = 1'b1; waddr = 5'd3; wdata = 32'hDEAD_BEEF; raddr1 = 5'd3; raddr2 = 5'd3;
    #1 check_eq("no_bypass_rd1", rdata1, 32'h0);
    check_eq("no_bypass_rd2", rdata2, 32'h0);
    @(posedge clk);
    model_regs[3] = 32'hDEAD_BEEF;
    #1 wen = 1'b0;
    check_eq("wr3_rd1", rdata1, 32'hDEAD_BEEF);
    check_eq("wr3_rd2", rdata2, 32'hDEAD_BEEF);

    // x0 stays zero
    do_write(5'd0, 32'hFFFF_FFFF);
    raddr1 = 5'd0;
    #1 check_eq("x0_rd1", rdata1, 32'h0);

    // ALU directed
    alu_case("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu_case("sub_wrap", 4'd1, 32'h0, 32'h1, 32'hFFFF_FFFF);
    alu_case("slt_neg", 4'd3, 32'hFFFF_FFFF, 32'h1, 32'h1);
    alu_case("sltu_big", 4'd4, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu_case("sra_shamt", 4'd7, 32'h8000_0000, 32'h21, 32'hC000_0000);
    alu_case("srl_shamt", 4'd6, 32'h8000_0000, 32'h21, 32'h4000_0000);
    alu_case("sll_31", 4'd2, 32'h1, 32'd31, 32'h8000_0000);
    alu_case("passb", 4'd10, 32'hFFFF_0000, 32'h1234_5000, 32'h1234_5000);
    alu_case("op12_zero", 4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
    alu_case("xor", 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    alu_case("or", 4'd8, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    alu_case("and", 4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);

    // decoder sweep
    for (int f = 0; f < 8; f++) begin
      funct3 = 3'(f);
      exp_d = 8'h0;
      exp_d[f] = 1'b1;
      #1 check_eq($sformatf("dec_%0d", f), {24'h0, funct3_d}, {24'h0, exp_d});
      check_eq($sformatf("dec_onehot_%0d", f), $countones(funct3_d), 32'd1);
    end

    // randomized traffic against the models
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      wen = ($urandom_range(0, 3) != 0);
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      raddr1 = 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      alu_op = 4'($urandom_range(0, 15));
      alu_src1 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      alu_src2 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      funct3 = 3'($urandom_range(0, 7));
      exp_q.push_back(model_regs[raddr1]);
      exp_q.push_back(model_regs[raddr2]);
      exp_q.push_back(alu_ref(alu_op, alu_src1, alu_src2));
      exp_d = 8'h0;
      exp_d[funct3] = 1'b1;
      exp_q.push_back({24'h0, exp_d});
      #1 check_eq("rnd_rd1", rdata1, exp_q.pop_front());
      check_eq("rnd_rd2", rdata2, exp_q.pop_front());
      check_eq($sformatf("rnd_alu_op%0d", alu_op), alu_result, exp_q.pop_front());
      check_eq("rnd_dec", {24'h0, funct3_d}, exp_q.pop_front());
      if (n % 97 == 50) begin
        // occasional mid-cycle async reset pulse
        #1 reset = 1'b0;
        model_clear();
        #1 check_eq("rnd_async_clr", rdata1, 32'h0);
        wen = 1'b0;
        #1 reset = 1'b1;
      end
      @(posedge clk);
      if (wen && waddr != 5'd0) model_regs[waddr] = wdata;
    end

    // final sweep of all registers
    @(negedge clk);
    wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1 check_eq($sformatf("sweep_rd1_x%0d", i), rdata1, model_regs[i]);
      check_eq($sformatf("sweep_rd2_x%0d", 31 - i), rdata2, model_regs[31 - i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
